mem_lsu: RTL and testbench

- Load/store unit that initiates accesses on the data port of the core's unified instruction/data RAM.
- Accepts byte-addressed RV32I load/store requests from the execute stage and drives the RAM's word-addressed, asynchronous-read, synchronous-write data port.
- Performs sub-word extraction and sign/zero extension for loads.
- Performs read-modify-write for SB/SH, because the RAM has no byte enables.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_lane.sv | 49 ++++
 rtl/mem_lsu.sv | 160 ++++++++++++++++
 tb/tb_mem_lsu.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states,
// and the byte-lane width used by the sub-word extract/merge logic.
// Imported by lsu_lane and mem_lsu.
package lsu_pkg;

  localparam int BYTE_W = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane datapath: load extract + sign/zero extend, and store read-modify-write merge.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: rword_i (word to extract from), old_i (word to merge into), wdata_i (right-aligned
// store data), alo_i (byte offset), funct3_i; load_o (extended data), store_o (merged word).
module lsu_lane
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rword_i,
  input  logic [DATA_WIDTH-1:0] old_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [1:0]            alo_i,
  input  logic [2:0]            funct3_i,
  output logic [DATA_WIDTH-1:0] load_o,
  output logic [DATA_WIDTH-1:0] store_o
);

  logic [BYTE_W-1:0]   byte_sel;
  logic [2*BYTE_W-1:0] half_sel;

  assign byte_sel = rword_i[{alo_i, 3'b000} +: BYTE_W];
  assign half_sel = alo_i[1] ? rword_i[DATA_WIDTH-1:2*BYTE_W] : rword_i[2*BYTE_W-1:0];

  always_comb begin
    load_o = rword_i;
    case (funct3_i)
      F3_B:    load_o = {{(DATA_WIDTH-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
      F3_BU:   load_o = {{(DATA_WIDTH-BYTE_W){1'b0}}, byte_sel};
      F3_H:    load_o = {{(DATA_WIDTH-2*BYTE_W){half_sel[2*BYTE_W-1]}}, half_sel};
      F3_HU:   load_o = {{(DATA_WIDTH-2*BYTE_W){1'b0}}, half_sel};
      default: load_o = rword_i;
    endcase
  end

  // The RAM has no byte enables, so narrow stores overwrite only their lane of the old word.
  always_comb begin
    store_o = old_i;
    case (funct3_i)
      F3_B: store_o[{alo_i, 3'b000} +: BYTE_W] = wdata_i[BYTE_W-1:0];
      F3_H: begin
        if (alo_i[1]) store_o[DATA_WIDTH-1:2*BYTE_W] = wdata_i[2*BYTE_W-1:0];
        else          store_o[2*BYTE_W-1:0]          = wdata_i[2*BYTE_W-1:0];
      end
      default: store_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// RV32I load/store unit driving a word-addressed, async-read, sync-write RAM data port.
// Latency from accept edge: load 2 cycles, store 3 (read-modify-write), fault 1.
// Backpressure: req_ready low while busy; no response backpressure (resp_valid is a pulse).
// Ports: clock/reset (sync, active-high); req_* request from execute; resp_* one-cycle
// completion; mem_* RAM data port. Build macro LSU_MISALIGN_TRAP_EN enables fault reporting;
// without it misaligned accesses are forced aligned and illegal funct3 behaves as W.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_misaligned,
  output logic                  mem_wEn,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  lsu_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            alo_q, alo_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  mis_q, mis_d;
  logic [DATA_WIDTH-1:0] rword_q, rword_d;
  logic [DATA_WIDTH-1:0] merged_q, merged_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;

  logic                  req_illegal;
  logic                  req_mis;
  logic [2:0]            req_f3_eff;
  logic [1:0]            req_alo_eff;
  logic [DATA_WIDTH-1:0] lane_load;
  logic [DATA_WIDTH-1:0] lane_store;

  // Bits above the RAM word address are deliberately dropped (accesses wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

  assign req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                       (req_funct3 == 3'b111) || (req_we && req_funct3[2]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_mis = req_illegal ||
                   (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                   ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
  assign req_f3_eff  = req_funct3;
  assign req_alo_eff = req_addr[1:0];
`else
  assign req_mis    = 1'b0;
  assign req_f3_eff = req_illegal ? F3_W : req_funct3;
  always_comb begin
    req_alo_eff = req_addr[1:0];
    if ((req_f3_eff == F3_H) || (req_f3_eff == F3_HU)) req_alo_eff[0] = 1'b0;
    if (req_f3_eff == F3_W)                            req_alo_eff    = 2'b00;
  end
`endif

  // Extract reads the word captured in READ; merge works on the live RAM word during READ.
  lsu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .rword_i  (rword_q),
    .old_i    (mem_read_data),
    .wdata_i  (wdata_q),
    .alo_i    (alo_q),
    .funct3_i (f3_q),
    .load_o   (lane_load),
    .store_o  (lane_store)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      f3_q     <= 3'b000;
      alo_q    <= 2'b00;
      wdata_q  <= '0;
      mis_q    <= 1'b0;
      rword_q  <= '0;
      merged_q <= '0;
      maddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      alo_q    <= alo_d;
      wdata_q  <= wdata_d;
      mis_q    <= mis_d;
      rword_q  <= rword_d;
      merged_q <= merged_d;
      maddr_q  <= maddr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    f3_d     = f3_q;
    alo_d    = alo_q;
    wdata_d  = wdata_q;
    mis_d    = mis_q;
    rword_d  = rword_q;
    merged_d = merged_q;
    maddr_d  = maddr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_f3_eff;
          alo_d   = req_alo_eff;
          wdata_d = req_wdata;
          mis_d   = req_mis;
          if (req_mis) begin
            state_d = RESP;
          end else begin
            // Address only moves when the RAM is really accessed; it holds otherwise.
            maddr_d = req_addr[ADDR_WIDTH+1:2];
            state_d = READ;
          end
        end
      end
      READ: begin
        rword_d = mem_read_data;
        if (we_q) begin
          merged_d = lane_store;
          state_d  = WRITE;
        end else begin
          state_d  = RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gating with reset makes an interrupted WRITE/RESP produce nothing in the reset cycle.
  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = (state_q == RESP) && !reset;
  assign mem_wEn        = (state_q == WRITE) && !reset;
  assign mem_address    = maddr_q;
  assign mem_write_data = mem_wEn ? merged_q : '0;
  assign resp_rdata     = (resp_valid && !we_q && !mis_q) ? lane_load : '0;
`ifdef LSU_MISALIGN_TRAP_EN
  assign resp_misaligned = resp_valid && mis_q;
`else
  assign resp_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a small behavioural RAM on the data port.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_lsu;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        mem_wEn;
  logic [15:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int check_cnt = 0;
  int pass_cnt  = 0;

  // RAM model: async read, sync write; preload port shares the single write process.
  logic [31:0] ram [0:1023];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;

  assign mem_read_data = ram[mem_address[9:0]];

  always @(posedge clock) begin
    if (pre_we)       ram[pre_addr]          <= pre_data;
    else if (mem_wEn) ram[mem_address[9:0]] <= mem_write_data;
  end

  mem_lsu dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .mem_wEn         (mem_wEn),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .mem_read_data   (mem_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clock);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  // Presents one request while IDLE; returns at the negedge after the accept edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    preload(10'h010, 32'h80FF7F01);
    preload(10'h011, 32'h55555555);
    preload(10'h012, 32'h11223344);
    @(negedge clock);
    check_cnt++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready);
    else pass_cnt++;
    check_cnt++;
    if ({resp_valid, resp_misaligned, mem_wEn} !== 3'b000)
      $display("FAIL reset_flags: got %b expected 000", {resp_valid, resp_misaligned, mem_wEn});
    else pass_cnt++;
    check_cnt++;
    if ({resp_rdata, mem_write_data, mem_address} !== 80'h0)
      $display("FAIL reset_data: got %h/%h/%h expected 0", resp_rdata, mem_write_data, mem_address);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_load_ext();
    logic [31:0] addrs [7] = '{32'h41, 32'h43, 32'h43, 32'h42, 32'h42, 32'h42, 32'h40};
    logic [2:0]  f3s   [7] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
    logic [31:0] exps  [7] = '{32'h0000007F, 32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                               32'h000080FF, 32'hFFFFFFFF, 32'h80FF7F01};
    for (int i = 0; i < 7; i++) begin
      issue(1'b0, f3s[i], addrs[i], 32'h0);
      check_cnt++;
      if (resp_valid !== 1'b0 || mem_address !== 16'h0010)
        $display("FAIL load%0d_read_phase: got valid=%b addr=%h expected 0/0010", i, resp_valid, mem_address);
      else pass_cnt++;
      @(negedge clock);
      check_cnt++;
      if (resp_valid !== 1'b1 || resp_misaligned !== 1'b0)
        $display("FAIL load%0d_valid: got %b/%b expected 1/0", i, resp_valid, resp_misaligned);
      else pass_cnt++;
      check_cnt++;
      if (resp_rdata !== exps[i])
        $display("FAIL load%0d_data: got %h expected %h", i, resp_rdata, exps[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_store_merge();
    logic [31:0] addrs [3] = '{32'h42, 32'h44, 32'h46};
    logic [2:0]  f3s   [3] = '{3'b000, 3'b010, 3'b001};
    logic [31:0] wds   [3] = '{32'h123456AA, 32'hDEADBEEF, 32'hFFFF1234};
    logic [31:0] exps  [3] = '{32'h80AA7F01, 32'hDEADBEEF, 32'h1234BEEF};
    logic [15:0] waddr [3] = '{16'h0010, 16'h0011, 16'h0011};
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, f3s[i], addrs[i], wds[i]);
      check_cnt++;
      if (mem_wEn !== 1'b0 || resp_valid !== 1'b0)
        $display("FAIL store%0d_read_phase: got wen=%b valid=%b expected 0/0", i, mem_wEn, resp_valid);
      else pass_cnt++;
      @(negedge clock);
      check_cnt++;
      if (mem_wEn !== 1'b1 || mem_write_data !== exps[i] || mem_address !== waddr[i])
        $display("FAIL store%0d_write: got wen=%b data=%h addr=%h expected 1/%h/%h",
                 i, mem_wEn, mem_write_data, mem_address, exps[i], waddr[i]);
      else pass_cnt++;
      @(negedge clock);
      check_cnt++;
      if (resp_valid !== 1'b1 || mem_wEn !== 1'b0 || resp_rdata !== 32'h0 || mem_write_data !== 32'h0)
        $display("FAIL store%0d_resp: got valid=%b wen=%b rdata=%h wdata=%h expected 1/0/0/0",
                 i, resp_valid, mem_wEn, resp_rdata, mem_write_data);
      else pass_cnt++;
    end
  endtask

  task automatic test_readback();
    // Third entry exercises the modulo wrap: bit 18 lies above the RAM word address.
    logic [31:0] addrs [3] = '{32'h40, 32'h44, 32'h0004_0040};
    logic [31:0] exps  [3] = '{32'h80AA7F01, 32'h1234BEEF, 32'h80AA7F01};
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 3'b010, addrs[i], 32'h0);
      @(negedge clock);
      check_cnt++;
      if (resp_valid !== 1'b1 || resp_rdata !== exps[i])
        $display("FAIL readback%0d: got valid=%b data=%h expected 1/%h", i, resp_valid, resp_rdata, exps[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
    logic [31:0] addrs [3] = '{32'h42, 32'h43, 32'h40};
    logic [2:0]  f3s   [3] = '{3'b010, 3'b001, 3'b100};
    logic        wes   [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      issue(wes[i], f3s[i], addrs[i], 32'hFFFFFFFF);
      check_cnt++;
      if (resp_valid !== 1'b1 || resp_misaligned !== 1'b1 || resp_rdata !== 32'h0 || mem_wEn !== 1'b0)
        $display("FAIL fault%0d: got valid=%b mis=%b rdata=%h wen=%b expected 1/1/0/0",
                 i, resp_valid, resp_misaligned, resp_rdata, mem_wEn);
      else pass_cnt++;
      @(negedge clock);
      check_cnt++;
      if (resp_valid !== 1'b0 || mem_wEn !== 1'b0 || req_ready !== 1'b1)
        $display("FAIL fault%0d_after: got valid=%b wen=%b ready=%b expected 0/0/1",
                 i, resp_valid, mem_wEn, req_ready);
      else pass_cnt++;
    end
`else
    // Misaligned H/W are forced aligned; illegal funct3 011 reads as W.
    logic [31:0] addrs [3] = '{32'h42, 32'h43, 32'h41};
    logic [2:0]  f3s   [3] = '{3'b010, 3'b001, 3'b011};
    logic [31:0] exps  [3] = '{32'h80AA7F01, 32'hFFFF80AA, 32'h80AA7F01};
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, f3s[i], addrs[i], 32'h0);
      check_cnt++;
      if (resp_valid !== 1'b0)
        $display("FAIL noalign%0d_early: got valid=%b expected 0", i, resp_valid);
      else pass_cnt++;
      @(negedge clock);
      check_cnt++;
      if (resp_valid !== 1'b1 || resp_misaligned !== 1'b0 || resp_rdata !== exps[i])
        $display("FAIL noalign%0d: got valid=%b mis=%b data=%h expected 1/0/%h",
                 i, resp_valid, resp_misaligned, resp_rdata, exps[i]);
      else pass_cnt++;
    end
`endif
  endtask

  task automatic test_reset_in_write();
    issue(1'b1, 3'b000, 32'h48, 32'h99);
    @(negedge clock);
    check_cnt++;
    if (mem_wEn !== 1'b1)
      $display("FAIL rst_write_reached: got wen=%b expected 1", mem_wEn);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    check_cnt++;
    if (mem_wEn !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL rst_write_suppressed: got wen=%b valid=%b expected 0/0", mem_wEn, resp_valid);
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b0;
    check_cnt++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_wEn !== 1'b0)
      $display("FAIL rst_after: got ready=%b valid=%b wen=%b expected 1/0/0", req_ready, resp_valid, mem_wEn);
    else pass_cnt++;
    @(negedge clock);
    check_cnt++;
    if (resp_valid !== 1'b0)
      $display("FAIL rst_no_resp: got valid=%b expected 0", resp_valid);
    else pass_cnt++;
    issue(1'b0, 3'b010, 32'h48, 32'h0);
    @(negedge clock);
    check_cnt++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h11223344)
      $display("FAIL rst_ram_untouched: got valid=%b data=%h expected 1/11223344", resp_valid, resp_rdata);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h44; req_wdata = 32'h0;
    for (int i = 0; i < 9; i++) begin
      check_cnt++;
      if (req_ready !== (i % 3 == 0))
        $display("FAIL b2b_ready%0d: got %b expected %b", i, req_ready, (i % 3 == 0));
      else pass_cnt++;
      check_cnt++;
      if (resp_valid !== (i % 3 == 2) || (i % 3 == 2 && resp_rdata !== 32'h1234BEEF))
        $display("FAIL b2b_resp%0d: got valid=%b data=%h expected %b/1234beef",
                 i, resp_valid, resp_rdata, (i % 3 == 2));
      else pass_cnt++;
      @(negedge clock);
    end
    req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    pre_we = 1'b0; pre_addr = 10'h0; pre_data = 32'h0;
    test_reset();
    test_load_ext();
    test_store_merge();
    test_readback();
    test_misalign();
    test_reset_in_write();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
